// File: rtl/instruction_fetch_unit.sv
// Fetches one instruction word per retire: IDLE -> REQ (until ack or timeout) -> VALID (until pcLoad); ERR is terminal.
// Latency: ack to instrValid is one cycle; no backpressure on memory beyond holding imemReq until imemAck.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] nextPC,
   input  logic        pcLoad,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemAck,
   input  logic [31:0] imemData,
   output logic [31:0] currentPC,
   output logic [31:0] instr,
   output logic        instrValid,
   output logic [31:0] instrCount,
   output logic [1:0]  errCode
);

   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_VALID = 2'd2,
      S_ERR   = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_q, pc_nxt;
   logic [31:0] instr_q, instr_nxt;
   logic        valid_q, valid_nxt;
   logic [31:0] count_q, count_nxt;
   logic [1:0]  err_q, err_nxt;
   logic [7:0]  tmo_q, tmo_nxt;
   logic        req_q, req_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= 32'h0;
         valid_q <= 1'b0;
         count_q <= 32'h0;
         err_q   <= 2'b00;
         tmo_q   <= 8'h0;
         req_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         pc_q    <= pc_nxt;
         instr_q <= instr_nxt;
         valid_q <= valid_nxt;
         count_q <= count_nxt;
         err_q   <= err_nxt;
         tmo_q   <= tmo_nxt;
         req_q   <= req_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_q;
      instr_nxt = instr_q;
      valid_nxt = valid_q;
      count_nxt = count_q;
      err_nxt   = err_q;
      tmo_nxt   = tmo_q;
      case (state)
         S_IDLE: begin
            state_nxt = S_REQ;
            tmo_nxt   = 8'h0;
         end
         S_REQ: begin
            // An ack on the timeout cycle still completes the fetch.
            if (imemAck) begin
               instr_nxt = imemData;
               valid_nxt = 1'b1;
               count_nxt = count_q + 32'd1;
               state_nxt = S_VALID;
            end else if (tmo_q + 8'd1 == TMO_LIMIT) begin
               err_nxt   = 2'b10;
               state_nxt = S_ERR;
            end else begin
               tmo_nxt = tmo_q + 8'd1;
            end
         end
         S_VALID: begin
            if (pcLoad) begin
               pc_nxt    = nextPC;
               valid_nxt = 1'b0;
               if (nextPC[1:0] != 2'b00) begin
                  err_nxt   = 2'b01;
                  state_nxt = S_ERR;
               end else begin
                  tmo_nxt   = 8'h0;
                  state_nxt = S_REQ;
               end
            end
         end
         S_ERR: begin
            valid_nxt = 1'b0;
         end
         default: state_nxt = S_IDLE;
      endcase
      req_nxt = (state_nxt == S_REQ);
   end

   assign imemReq    = req_q;
   assign imemAddr   = pc_q;
   assign currentPC  = pc_q;
   assign instr      = instr_q;
   assign instrValid = valid_q;
   assign instrCount = count_q;
   assign errCode    = err_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, corner sequences, and random traffic vs a transaction model.
module tb_instruction_fetch_unit;

   localparam int          TO  = 4;
   localparam logic [31:0] RPC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] nextPC = 32'h0;
   logic        pcLoad = 1'b0;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemAck = 1'b0;
   logic [31:0] imemData = 32'h0;
   logic [31:0] currentPC;
   logic [31:0] instr;
   logic        instrValid;
   logic [31:0] instrCount;
   logic [1:0]  errCode;

   int n_vec = 0;
   int n_bad = 0;

   instruction_fetch_unit #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .nextPC(nextPC), .pcLoad(pcLoad),
      .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
      .currentPC(currentPC), .instr(instr), .instrValid(instrValid),
      .instrCount(instrCount), .errCode(errCode)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_exp(input string tag, input logic req, input logic vld,
                            input logic [31:0] pc, input logic [31:0] ins,
                            input logic [31:0] cnt, input logic [1:0] err);
      chk({tag, "_req"},   {31'h0, imemReq},    {31'h0, req});
      chk({tag, "_vld"},   {31'h0, instrValid}, {31'h0, vld});
      chk({tag, "_pc"},    currentPC,           pc);
      chk({tag, "_addr"},  imemAddr,            pc);
      chk({tag, "_instr"}, instr,               ins);
      chk({tag, "_cnt"},   instrCount,          cnt);
      chk({tag, "_err"},   {30'h0, errCode},    {30'h0, err});
   endtask

   // Transaction-level model: phase 0 = just out of reset, 1 = waiting for memory,
   // 2 = holding an instruction, 3 = dead until reset.
   int          m_phase;
   int          m_wait;
   logic [31:0] m_pc, m_instr, m_cnt;
   logic        m_vld;
   logic [1:0]  m_err;

   task automatic model_reset();
      m_phase = 0; m_wait = 0; m_pc = RPC; m_instr = 0; m_cnt = 0; m_vld = 0; m_err = 0;
   endtask

   task automatic model_edge();
      case (m_phase)
         0: begin m_phase = 1; m_wait = 0; end
         1: begin
            if (imemAck) begin
               m_instr = imemData; m_vld = 1; m_cnt = m_cnt + 1; m_phase = 2;
            end else begin
               m_wait++;
               if (m_wait == TO) begin m_err = 2'b10; m_phase = 3; end
            end
         end
         2: begin
            if (pcLoad) begin
               m_pc = nextPC; m_vld = 0;
               if (nextPC % 4 != 0) begin m_err = 2'b01; m_phase = 3; end
               else begin m_phase = 1; m_wait = 0; end
            end
         end
         default: ;
      endcase
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst_n = 1'b0; imemAck = 1'b0; pcLoad = 1'b0;
      #1 check_exp("reset_async", 1'b0, 1'b0, RPC, 32'h0, 32'h0, 2'b00);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
   endtask

   typedef struct {
      logic        ack;
      logic [31:0] data;
      logic        ld;
      logic [31:0] npc;
      logic        e_req;
      logic        e_vld;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic [31:0] e_cnt;
      logic [1:0]  e_err;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int          ack_pct;
      int          dead_cycles;
      logic [31:0] r;

      tbl[0] = '{1'b1, 32'hAAAA_0001, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0, 32'h0,         32'd0, 2'b00};
      tbl[1] = '{1'b1, 32'h1111_0000, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0, 32'h1111_0000, 32'd1, 2'b00};
      tbl[2] = '{1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0, 32'h1111_0000, 32'd1, 2'b00};
      tbl[3] = '{1'b0, 32'h0,         1'b1, 32'h4,  1'b1, 1'b0, 32'h4, 32'h1111_0000, 32'd1, 2'b00};
      tbl[4] = '{1'b0, 32'h0,         1'b0, 32'h100,1'b1, 1'b0, 32'h4, 32'h1111_0000, 32'd1, 2'b00};
      tbl[5] = '{1'b0, 32'h0,         1'b0, 32'h100,1'b1, 1'b0, 32'h4, 32'h1111_0000, 32'd1, 2'b00};
      tbl[6] = '{1'b1, 32'h2000_0001, 1'b0, 32'h100,1'b0, 1'b1, 32'h4, 32'h2000_0001, 32'd2, 2'b00};
      tbl[7] = '{1'b0, 32'h0,         1'b1, 32'h6,  1'b0, 1'b0, 32'h6, 32'h2000_0001, 32'd2, 2'b01};
      tbl[8] = '{1'b1, 32'hFFFF_FFFF, 1'b1, 32'h8,  1'b0, 1'b0, 32'h6, 32'h2000_0001, 32'd2, 2'b01};
      tbl[9] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 32'h8,  1'b0, 1'b0, 32'h6, 32'h2000_0001, 32'd2, 2'b01};

      // Directed table: first fetch, aligned reload, misaligned reload into ERR.
      do_reset();
      check_exp("idle", 1'b0, 1'b0, RPC, 32'h0, 32'h0, 2'b00);
      for (int i = 0; i < 10; i++) begin
         imemAck = tbl[i].ack; imemData = tbl[i].data; pcLoad = tbl[i].ld; nextPC = tbl[i].npc;
         @(posedge clk);
         #1 check_exp($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_vld, tbl[i].e_pc,
                      tbl[i].e_instr, tbl[i].e_cnt, tbl[i].e_err);
      end

      // Ack withheld: request stays up TO cycles, then timeout.
      do_reset();
      imemAck = 1'b0; pcLoad = 1'b0;
      for (int k = 1; k <= TO; k++) begin
         @(posedge clk);
         #1 chk($sformatf("tmo_req%0d", k), {31'h0, imemReq}, 32'h1);
      end
      @(posedge clk);
      #1 check_exp("tmo_err", 1'b0, 1'b0, RPC, 32'h0, 32'h0, 2'b10);
      imemAck = 1'b1; pcLoad = 1'b1; nextPC = 32'h40;
      repeat (2) @(posedge clk);
      #1 check_exp("tmo_stuck", 1'b0, 1'b0, RPC, 32'h0, 32'h0, 2'b10);

      // Ack on the last permitted cycle wins over the timeout.
      do_reset();
      imemAck = 1'b0; pcLoad = 1'b0;
      repeat (TO) @(posedge clk);
      #1 imemAck = 1'b1; imemData = 32'h3C3C_0000;
      @(posedge clk);
      #1 check_exp("tmo_edge_ack", 1'b0, 1'b1, RPC, 32'h3C3C_0000, 32'd1, 2'b00);

      // Reset asserted between edges mid-request with ack high.
      do_reset();
      @(posedge clk);
      #1 imemAck = 1'b1; imemData = 32'h5555_AAAA;
      #2 rst_n = 1'b0;
      #1 check_exp("arst_mid", 1'b0, 1'b0, RPC, 32'h0, 32'h0, 2'b00);
      @(posedge clk);
      #1 check_exp("arst_held", 1'b0, 1'b0, RPC, 32'h0, 32'h0, 2'b00);
      rst_n = 1'b1; imemAck = 1'b0;

      // Fetch counter wraps from all-ones to zero.
      do_reset();
      imemAck = 1'b1; imemData = 32'h1;
      repeat (2) @(posedge clk);
      #1 force dut.count_q = 32'hFFFF_FFFF;
      #1 release dut.count_q;
      imemAck = 1'b0; pcLoad = 1'b1; nextPC = 32'h10;
      @(posedge clk);
      #1 pcLoad = 1'b0; imemAck = 1'b1; imemData = 32'h7777_0000;
      @(posedge clk);
      #1 check_exp("wrap", 1'b0, 1'b1, 32'h10, 32'h7777_0000, 32'h0, 2'b00);

      // Random traffic against the model.
      do_reset();
      ack_pct = 50;
      dead_cycles = 0;
      for (int i = 0; i < 3000; i++) begin
         if ((m_phase == 3 && dead_cycles >= 3) || $urandom_range(0, 299) == 0) begin
            do_reset();
            dead_cycles = 0;
            case ($urandom_range(0, 2))
               0:       ack_pct = 10;
               1:       ack_pct = 50;
               default: ack_pct = 90;
            endcase
         end
         imemAck  = ($urandom_range(0, 99) < ack_pct);
         imemData = $urandom;
         pcLoad   = ($urandom_range(0, 2) == 0);
         r = $urandom;
         if ($urandom_range(0, 9) != 0) r[1:0] = 2'b00;
         else if (r[1:0] == 2'b00) r[1:0] = 2'b11;
         nextPC = r;
         @(posedge clk);
         model_edge();
         #1 check_exp("rand", m_phase == 1, m_vld, m_pc, m_instr, m_cnt, m_err);
         if (m_phase == 3) dead_cycles++;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: TIMEOUT, 16, max cycles in REQ without imemAck before a timeout error (legal range 2..255).
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: nextPC  input  32  next-instruction address from the PC update stage.
REQ-006 Port: pcLoad  input  1  current instruction retired; accept nextPC.
REQ-007 Port: imemReq  output  1  instruction memory read request.
REQ-008 Port: imemAddr  output  32  instruction memory read address, equals currentPC.
REQ-009 Port: imemAck  input  1  memory read complete; imemData valid this cycle.
REQ-010 Port: imemData  input  32  instruction word from memory.
REQ-011 Port: currentPC  output  32  address of the instruction being fetched or held.
REQ-012 Port: instr  output  32  latched instruction word.
REQ-013 Port: instrValid  output  1  instr holds the instruction at currentPC.
REQ-014 Port: instrCount  output  32  number of completed fetches.
REQ-015 Port: errCode  output  2  sticky error: 00 none, 01 misaligned PC, 10 memory timeout.

Function
REQ-016 Four states: IDLE, REQ, VALID, ERR; all outputs are registered (Moore).
REQ-017 IDLE: occupied exactly one cycle after reset release, then REQ unconditionally.
REQ-018 REQ: imemReq=1 and imemAddr=currentPC; remains in REQ until imemAck is sampled high.
REQ-019 REQ with imemAck=1 at an edge: instr<=imemData, instrValid<=1, instrCount<=instrCount+1 (modulo 2^32, FFFF_FFFF wraps to 0), next state VALID.
REQ-020 Ack-to-valid latency is one cycle; imemReq drops in the same cycle instrValid rises.
REQ-021 VALID: imemReq=0; instr, currentPC, instrValid held stable until pcLoad is sampled high.
REQ-022 VALID with pcLoad=1 and nextPC[1:0]==00: currentPC<=nextPC, instrValid<=0, next state REQ.
REQ-023 VALID with pcLoad=1 and nextPC[1:0]!=00: currentPC<=nextPC, instrValid<=0, errCode<=01, next state ERR.
REQ-024 Timeout counter clears on REQ entry and increments each REQ cycle without ack; reaching TIMEOUT without ack gives errCode<=10, imemReq<=0, next state ERR.
REQ-025 Ack in the cycle the counter reaches TIMEOUT takes priority; the fetch completes normally.
REQ-026 ERR is terminal until reset: imemReq=0, instrValid=0, errCode held, pcLoad and imemAck ignored.
REQ-027 pcLoad outside VALID is ignored; imemAck outside REQ is ignored and does not change instr.
REQ-028 nextPC is sampled only on the accepting edge of REQ-022/023; later changes have no effect.
REQ-029 Minimum cycle per instruction is 2 (REQ with immediate ack, then VALID with immediate pcLoad).

Reset
REQ-030 rst_n low forces immediately, regardless of clk: state=IDLE, currentPC=imemAddr=RESET_PC, imemReq=0, instr=0, instrValid=0, instrCount=0, errCode=00, timeout counter=0.
REQ-031 Reset asserted mid-REQ or mid-VALID aborts the operation; an imemAck arriving during reset is ignored.
REQ-032 First imemReq is seen in the second cycle after rst_n deasserts (IDLE, then REQ).

Verification
REQ-033 Reset release with ack tied high -> imemReq=1, imemAddr=0000_0000 in cycle 2; instrValid=1 and instr=imemData in cycle 3; instrCount=1.
REQ-034 In VALID, nextPC=0000_0004 with pcLoad pulse -> next cycle currentPC=0000_0004, instrValid=0, imemReq=1; data 2000_0001 acked 3 cycles later -> instr=2000_0001, instrCount=2.
REQ-035 In VALID, nextPC=0000_0006 with pcLoad -> errCode=01, state ERR; further pcLoad/imemAck pulses change nothing until rst_n.
REQ-036 TIMEOUT=4, ack withheld -> imemReq high 4 cycles then 0, errCode=10; second run with ack on cycle 4 -> normal completion, errCode=00.
REQ-037 instrCount preloaded via 2^32-1 fetches (or forced) to FFFF_FFFF, one more fetch -> instrCount=0000_0000.
REQ-038 rst_n pulsed low between clock edges during REQ with imemAck high -> outputs reach reset values without a clk edge; instr stays 0, instrCount stays 0.
